// File: rtl/quiz_pkg.sv
// quiz_pkg -- shared types and constants for the quiz host controller.
//   state_e         : host FSM states (IDLE, CLEARING, ARMED, ANSWERING)
//   OWNER_*         : answer_owner encodings (11 is never driven)
//   SCORE_W_DEFAULT : default score width in bits
package quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEARING  = 2'd1,
    ST_ARMED     = 2'd2,
    ST_ANSWERING = 2'd3
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_U1   = 2'b01;
  localparam logic [1:0] OWNER_U2   = 2'b10;

  localparam int SCORE_W_DEFAULT = 8;

endpackage

// File: rtl/quiz_answer_timer.sv
// quiz_answer_timer -- loadable up/down counter shared by the host FSM.
// It counts down to pace the arbiter-clear window and counts up to time the
// judge's answer window.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset (count -> 0)
//   i_clear      : synchronous clear to 0 (highest priority)
//   i_load       : synchronous load of i_load_val
//   i_load_val   : value loaded when i_load is high
//   i_en         : count enable
//   i_down       : 1 = count down, 0 = count up
//   o_clear_done : count is 0 (end of a down-counted clear window)
//   o_expire     : count equals EXPIRE_VAL (last cycle of the answer window)
module quiz_answer_timer #(
  parameter int CNT_W      = 5,
  parameter int EXPIRE_VAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_down,
  output logic             o_clear_done,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] EXPIRE_CNT = CNT_W'(EXPIRE_VAL);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_down ? (r_count - 1'b1) : (r_count + 1'b1);
    end
  end

  assign o_clear_done = (r_count == '0);
  assign o_expire     = (r_count == EXPIRE_CNT);

endmodule

// File: rtl/quiz_host_controller.sv
// quiz_host_controller -- quiz host sequencer around a fastest-finger arbiter.
// Arms the arbiter, latches which contestant buzzed, waits for the judge's
// verdict (or a timeout) and keeps running scores.
// Build option: define QUIZ_PENALTY_EN to make wrong answers and timeouts
// cost the answering contestant one point (saturating at 0). Without it,
// wrong answers and timeouts leave the scores untouched.
// Ports:
//   clk                        : clock, rising edge
//   rst                        : asynchronous active-low reset
//   start_round                : one-cycle request to arm a round (IDLE only)
//   winner_user1/winner_user2  : latched winner lines from the arbiter
//   judge_correct/judge_wrong  : one-cycle verdict pulses
//   arb_clear                  : active-high clear to the arbiter
//   answer_owner               : 00 none, 01 user1, 10 user2
//   score_user1/score_user2    : running scores, saturating
//   round_done/tie_seen/timeout: one-cycle event pulses
//   busy                       : high in every state except IDLE
module quiz_host_controller
  import quiz_pkg::*;
#(
  parameter int ANSWER_TIMEOUT = 1000,
  parameter int CLEAR_CYCLES   = 2,
  parameter int SCORE_W        = SCORE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_round,
  input  logic               winner_user1,
  input  logic               winner_user2,
  input  logic               judge_correct,
  input  logic               judge_wrong,
  output logic               arb_clear,
  output logic [1:0]         answer_owner,
  output logic [SCORE_W-1:0] score_user1,
  output logic [SCORE_W-1:0] score_user2,
  output logic               round_done,
  output logic               tie_seen,
  output logic               timeout,
  output logic               busy
);

  // One counter serves both windows, so size it for the longer one.
  localparam int TMR_MAX = (ANSWER_TIMEOUT > CLEAR_CYCLES) ? ANSWER_TIMEOUT : CLEAR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLEAR_CYCLES - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : (v + 1'b1);
  endfunction

`ifdef QUIZ_PENALTY_EN
  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    return (v == '0) ? v : (v - 1'b1);
  endfunction
`endif

  state_e             r_state;
  logic               r_arb_clear;
  logic [1:0]         r_owner;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_round_done;
  logic               r_tie;
  logic               r_timeout;
  logic               r_busy;

  logic w_one_win;
  logic w_tie;
  logic w_correct;
  logic w_wrong;
  logic w_tmr_clear;
  logic w_tmr_load;
  logic w_tmr_en;
  logic w_tmr_down;
  logic w_clear_done;
  logic w_expire;

  assign w_one_win = winner_user1 ^ winner_user2;
  assign w_tie     = winner_user1 & winner_user2;
  // Contradictory verdicts cancel each other out.
  assign w_correct = judge_correct & ~judge_wrong;
  assign w_wrong   = judge_wrong & ~judge_correct;

  // Load the clear window when entering CLEARING (from IDLE or after a tie);
  // hold the counter at 0 in IDLE/ARMED so ANSWERING always starts from 0.
  assign w_tmr_load  = ((r_state == ST_IDLE) && start_round) ||
                       ((r_state == ST_ARMED) && w_tie);
  assign w_tmr_clear = ((r_state == ST_IDLE) && !start_round) ||
                       ((r_state == ST_ARMED) && !w_tie);
  assign w_tmr_en    = ((r_state == ST_CLEARING) && !w_clear_done) ||
                       (r_state == ST_ANSWERING);
  assign w_tmr_down  = (r_state == ST_CLEARING);

  quiz_answer_timer #(
    .CNT_W      (TMR_W),
    .EXPIRE_VAL (ANSWER_TIMEOUT - 1)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_tmr_clear),
    .i_load       (w_tmr_load),
    .i_load_val   (CLR_LOAD),
    .i_en         (w_tmr_en),
    .i_down       (w_tmr_down),
    .o_clear_done (w_clear_done),
    .o_expire     (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_arb_clear  <= 1'b1;
      r_owner      <= OWNER_NONE;
      r_score1     <= '0;
      r_score2     <= '0;
      r_round_done <= 1'b0;
      r_tie        <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      r_tie        <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_round) begin
            r_state <= ST_CLEARING;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEARING: begin
          if (w_clear_done) begin
            r_state     <= ST_ARMED;
            r_arb_clear <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (w_tie) begin
            // Nobody wins a tie: clear the arbiter and re-arm.
            r_tie       <= 1'b1;
            r_state     <= ST_CLEARING;
            r_arb_clear <= 1'b1;
          end else if (w_one_win) begin
            r_state <= ST_ANSWERING;
            r_owner <= winner_user1 ? OWNER_U1 : OWNER_U2;
          end
        end
        ST_ANSWERING: begin
          // A verdict on the expiry cycle wins over the timeout.
          if (w_correct || w_wrong || w_expire) begin
            r_state      <= ST_IDLE;
            r_arb_clear  <= 1'b1;
            r_owner      <= OWNER_NONE;
            r_busy       <= 1'b0;
            r_round_done <= 1'b1;
            if (w_correct) begin
              if (r_owner == OWNER_U1) begin
                r_score1 <= sat_inc(r_score1);
              end else if (r_owner == OWNER_U2) begin
                r_score2 <= sat_inc(r_score2);
              end
            end else begin
              r_timeout <= !w_wrong;
`ifdef QUIZ_PENALTY_EN
              if (r_owner == OWNER_U1) begin
                r_score1 <= sat_dec(r_score1);
              end else if (r_owner == OWNER_U2) begin
                r_score2 <= sat_dec(r_score2);
              end
`else
`endif
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb_clear    = r_arb_clear;
  assign answer_owner = r_owner;
  assign score_user1  = r_score1;
  assign score_user2  = r_score2;
  assign round_done   = r_round_done;
  assign tie_seen     = r_tie;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

endmodule

// File: tb/tb_quiz_host_controller.sv
// tb_quiz_host_controller -- directed bench for quiz_host_controller with
// ANSWER_TIMEOUT=16, CLEAR_CYCLES=2. Stimulus pushes the expected event
// (round_done/tie_seen/timeout plus the scores after it) into a queue; a
// monitor pops and compares whenever the DUT raises an event pulse.
// Honours QUIZ_PENALTY_EN for expected penalty values.
module tb_quiz_host_controller;

  localparam int SW = 8;

  typedef struct packed {
    logic          rd;
    logic          tie;
    logic          to;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_round, winner_user1, winner_user2;
  logic          judge_correct, judge_wrong;
  logic          arb_clear;
  logic [1:0]    answer_owner;
  logic [SW-1:0] score_user1, score_user2;
  logic          round_done, tie_seen, timeout, busy;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_s1  = 0;
  int  m_s2  = 0;
  ev_t exp_q[$];
  ev_t mon_e;

  quiz_host_controller #(
    .ANSWER_TIMEOUT (16),
    .CLEAR_CYCLES   (2),
    .SCORE_W        (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_round   (start_round),
    .winner_user1  (winner_user1),
    .winner_user2  (winner_user2),
    .judge_correct (judge_correct),
    .judge_wrong   (judge_wrong),
    .arb_clear     (arb_clear),
    .answer_owner  (answer_owner),
    .score_user1   (score_user1),
    .score_user2   (score_user2),
    .round_done    (round_done),
    .tie_seen      (tie_seen),
    .timeout       (timeout),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push(input logic rd, input logic tie, input logic to);
    ev_t e;
    e.rd  = rd;
    e.tie = tie;
    e.to  = to;
    e.s1  = m_s1[SW-1:0];
    e.s2  = m_s2[SW-1:0];
    exp_q.push_back(e);
  endtask

  // start_round from IDLE, then walk through the 2-cycle clear window.
  task automatic arm(input bit do_chk);
    start_round = 1'b1;
    cyc();
    start_round = 1'b0;
    if (do_chk) begin
      chk("clear_cycle1", 32'(arb_clear), 1);
      chk("busy_clearing", 32'(busy), 1);
    end
    cyc();
    if (do_chk) chk("clear_cycle2", 32'(arb_clear), 1);
    cyc();
    if (do_chk) chk("armed_arb_clear", 32'(arb_clear), 0);
  endtask

  task automatic buzz(input logic u1, input logic u2);
    winner_user1 = u1;
    winner_user2 = u2;
    cyc();
    winner_user1 = 1'b0;
    winner_user2 = 1'b0;
  endtask

  task automatic correct_round_u1();
    arm(1'b0);
    buzz(1'b1, 1'b0);
    if (m_s1 < 255) m_s1++;
    push(1'b1, 1'b0, 1'b0);
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
  endtask

  // Scoreboard monitor: every event pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst && (round_done || tie_seen || timeout)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: rd=%0b tie=%0b to=%0b s1=%0d s2=%0d, none expected",
                 round_done, tie_seen, timeout, score_user1, score_user2);
      end else begin
        mon_e = exp_q.pop_front();
        if ({round_done, tie_seen, timeout, score_user1, score_user2} !== mon_e) begin
          n_bad++;
          $display("FAIL event: got rd=%0b tie=%0b to=%0b s1=%0d s2=%0d expected rd=%0b tie=%0b to=%0b s1=%0d s2=%0d",
                   round_done, tie_seen, timeout, score_user1, score_user2,
                   mon_e.rd, mon_e.tie, mon_e.to, mon_e.s1, mon_e.s2);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    start_round = 1'b0;
    winner_user1 = 1'b0;
    winner_user2 = 1'b0;
    judge_correct = 1'b0;
    judge_wrong = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arb_clear", 32'(arb_clear), 1);
    chk("rst_owner", 32'(answer_owner), 0);
    chk("rst_score1", 32'(score_user1), 0);
    chk("rst_score2", 32'(score_user2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({round_done, tie_seen, timeout}), 0);
    rst = 1'b1;
    cyc();
    chk("idle_arb_clear", 32'(arb_clear), 1);

    // Judge pulse in IDLE is ignored.
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
    chk("idle_judge_ignored", 32'(score_user1), 0);

    // Basic round: user1 buzzes, judged correct.
    arm(1'b1);
    start_round = 1'b1;
    cyc();
    start_round = 1'b0;
    chk("armed_start_ignored", 32'(arb_clear), 0);
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
    chk("armed_judge_owner", 32'(answer_owner), 0);
    buzz(1'b1, 1'b0);
    chk("owner_user1", 32'(answer_owner), 1);
    m_s1 = 1;
    push(1'b1, 1'b0, 1'b0);
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
    chk("done_busy", 32'(busy), 0);
    chk("done_arb_clear", 32'(arb_clear), 1);
    chk("done_owner", 32'(answer_owner), 0);
    chk("done_score1", 32'(score_user1), 1);

    // Tie: re-clear for 2 cycles, back to ARMED.
    arm(1'b1);
    push(1'b0, 1'b1, 1'b0);
    buzz(1'b1, 1'b1);
    chk("tie_clear1", 32'(arb_clear), 1);
    chk("tie_busy", 32'(busy), 1);
    cyc();
    chk("tie_clear2", 32'(arb_clear), 1);
    cyc();
    chk("tie_rearmed", 32'(arb_clear), 0);
    chk("tie_owner", 32'(answer_owner), 0);

    // Timeout: user2 buzzes, no verdict for 16 cycles.
    buzz(1'b0, 1'b1);
    chk("owner_user2", 32'(answer_owner), 2);
    push(1'b1, 1'b0, 1'b1);
    repeat (15) cyc();
    chk("pre_timeout_pulse", 32'(timeout), 0);
    chk("pre_timeout_busy", 32'(busy), 1);
    cyc();
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_score2", 32'(score_user2), 0);

    // Conflicting verdicts at timer=5 ignored, correct at timer=8 counts.
    arm(1'b0);
    buzz(1'b1, 1'b0);
    repeat (5) cyc();
    judge_correct = 1'b1;
    judge_wrong = 1'b1;
    cyc();
    judge_correct = 1'b0;
    judge_wrong = 1'b0;
    chk("both_verdicts_ignored", 32'(busy), 1);
    repeat (2) cyc();
    m_s1 = 2;
    push(1'b1, 1'b0, 1'b0);
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
    chk("single_increment", 32'(score_user1), 2);

    // Drive score_user1 to 255, then one more correct must saturate.
    while (m_s1 < 255) correct_round_u1();
    chk("score1_at_max", 32'(score_user1), 255);
    correct_round_u1();
    chk("score1_saturated", 32'(score_user1), 255);

    // Wrong answer from user1 at 255.
    arm(1'b0);
    buzz(1'b1, 1'b0);
`ifdef QUIZ_PENALTY_EN
    m_s1 = 254;
`else
    m_s1 = 255;
`endif
    push(1'b1, 1'b0, 1'b0);
    judge_wrong = 1'b1;
    cyc();
    judge_wrong = 1'b0;
    chk("wrong_score1", 32'(score_user1), 32'(m_s1));

    // Wrong answer from user2 at 0 stays 0.
    arm(1'b0);
    buzz(1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0);
    judge_wrong = 1'b1;
    cyc();
    judge_wrong = 1'b0;
    chk("wrong_score2_floor", 32'(score_user2), 0);

    // Reset in the middle of ANSWERING.
    arm(1'b0);
    buzz(1'b1, 1'b0);
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("midrst_arb_clear", 32'(arb_clear), 1);
    chk("midrst_owner", 32'(answer_owner), 0);
    chk("midrst_scores", 32'({score_user1, score_user2}), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pulses", 32'({round_done, tie_seen, timeout}), 0);
    m_s1 = 0;
    m_s2 = 0;
    cyc();
    rst = 1'b1;
    cyc();
    judge_correct = 1'b1;
    cyc();
    judge_correct = 1'b0;
    chk("post_rst_judge_score", 32'(score_user1), 0);
    chk("post_rst_judge_busy", 32'(busy), 0);

    repeat (3) cyc();
    chk("events_outstanding", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quiz_host_controller.md
QUIZ_HOST_CONTROLLER -- requirements
Module: quiz_host_controller

Interface
REQ-001 Parameter ANSWER_TIMEOUT, default 1000, cycles allowed for the judge to rule after a winner is latched (min 2).
REQ-002 Parameter CLEAR_CYCLES, default 2, cycles arb_clear stays high after start_round (min 1).
REQ-003 Parameter SCORE_W, default 8, score width in bits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start_round  in  1  one-cycle request to arm a new buzzer round.
REQ-007 winner_user1, winner_user2  in  1 each  latched winner lines from the fastest-finger arbiter.
REQ-008 judge_correct, judge_wrong  in  1 each  one-cycle judge verdict pulses.
REQ-009 arb_clear  out  1  active-high clear driven to the arbiter reset input.
REQ-010 answer_owner  out  2  00 none, 01 user1, 10 user2; 11 never driven.
REQ-011 score_user1, score_user2  out  SCORE_W each  running scores.
REQ-012 round_done, tie_seen, timeout  out  1 each  one-cycle event pulses.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, CLEARING, ARMED, ANSWERING.
REQ-015 IDLE: arb_clear=1, answer_owner=00; start_round -> CLEARING; start_round is ignored in all other states.
REQ-016 CLEARING: arb_clear=1 for exactly CLEAR_CYCLES cycles, then -> ARMED; winner inputs are ignored.
REQ-017 ARMED: arb_clear=0; exactly one winner line high at cycle N -> ANSWERING, answer_owner valid at N+1.
REQ-018 ARMED, both winner lines high in the same cycle: tie_seen pulses for 1 cycle, then -> CLEARING (re-arm), no score change.
REQ-019 ANSWERING: the answer timer starts at 0 on entry and increments each cycle; arb_clear=0; answer_owner is held.
REQ-020 judge_correct alone: owner score +1, saturating at 2^SCORE_W-1; round_done pulses; -> IDLE.
REQ-021 judge_wrong alone: penalty per REQ-027/028; round_done pulses; -> IDLE.
REQ-022 Timer reaches ANSWER_TIMEOUT-1 with no verdict: timeout and round_done pulse together; penalty per REQ-027/028; -> IDLE.
REQ-023 A verdict in the same cycle as expiry takes precedence over timeout; timeout does not pulse.
REQ-024 judge_correct and judge_wrong in the same cycle: both ignored; the timer keeps running.
REQ-025 Judge inputs are ignored outside ANSWERING; a score changes at most once per round.

Reset
REQ-026 While rst=0: state=IDLE, arb_clear=1, answer_owner=00, both scores=0, all pulses=0, busy=0, timer=0; an assertion mid-round aborts the round with no score update.

Configuration
REQ-027 With QUIZ_PENALTY_EN defined, wrong answers and timeouts decrement the owner score by 1, saturating at 0.
REQ-028 Without QUIZ_PENALTY_EN, wrong answers and timeouts leave the scores unchanged; all other behaviour is identical.

Structure
REQ-029 Package quiz_pkg holds the FSM state enum, the owner codes (OWNER_NONE/U1/U2) and the default SCORE_W.
REQ-030 Sub-module quiz_answer_timer holds the loadable down/up counter, with clear and expire outputs; all other logic is in quiz_host_controller.

Verification (ANSWER_TIMEOUT=16, CLEAR_CYCLES=2)
REQ-031 Reset release, start_round -> arb_clear high for 2 cycles then 0; winner_user1 -> answer_owner=01; judge_correct -> score_user1=1, round_done pulse, back to IDLE.
REQ-032 Simultaneous winner_user1 and winner_user2 in ARMED -> tie_seen pulse, arb_clear high for 2 cycles, return to ARMED, scores unchanged.
REQ-033 winner_user2 with no verdict for 16 cycles -> timeout and round_done on cycle 16; score_user2 = 0 (saturated) with QUIZ_PENALTY_EN, 0 without.
REQ-034 score_user1 preloaded to 255 by 255 correct rounds, then one more correct -> stays 255.
REQ-035 rst asserted while in ANSWERING -> all outputs immediately at reset values; a later judge_correct has no effect.
REQ-036 judge_correct and judge_wrong in the same cycle at timer=5, then judge_correct at timer=8 -> exactly one increment and one round_done.
